shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_shift_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Arbitrates two shift requesters onto one shared combinational shifter and
// returns the registered result through a valid/ready response port.
//
// Sequence per operation: IDLE (accept) -> EXEC (shifter evaluates the
// registered operands) -> RESP (result held until consumed).
//
// Configuration macro: SHIFT_ARB_RR_EN
//   defined   : round-robin between the two requesters; RESET_GRANT selects
//               the index that holds priority straight out of reset.
//   undefined : fixed priority, requester 0 always wins; RESET_GRANT unused.
//
// Parameters:
//   RESET_GRANT  requester index (0/1) holding round-robin priority after reset
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid / reqN_ready  request handshake for requester N (N = 0, 1)
//   reqN_amt/_data/_op       shift amount, operand, op (00 SRA, 01 SRL, 1x SLL)
//   shf_a/_b/_aluc           registered amount/operand/op to the shifter
//   shf_result, shf_cf       combinational shifter result and carry-out
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   requester owning the response
//   rsp_data, rsp_cf         registered shift result and carry-out
// -----------------------------------------------------------------------------
module shift_arbiter #(
  parameter int unsigned RESET_GRANT = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_amt,
  input  logic [31:0] req0_data,
  input  logic [1:0]  req0_op,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_amt,
  input  logic [31:0] req1_data,
  input  logic [1:0]  req1_op,

  output logic [4:0]  shf_a,
  output logic [31:0] shf_b,
  output logic [1:0]  shf_aluc,
  input  logic [31:0] shf_result,
  input  logic        shf_cf,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_cf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;

  // The shifter-facing registers double as the operand store for the
  // in-flight operation, so the shifter only ever sees registered values.
  logic [4:0]  shf_a_q, shf_a_d;
  logic [31:0] shf_b_q, shf_b_d;
  logic [1:0]  shf_aluc_q, shf_aluc_d;

  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_cf_q, rsp_cf_d;

  logic        grant;        // index selected this cycle
  logic        grant_valid;  // selected requester is presenting a request
  logic        accept;

  if (RESET_GRANT > 1) begin : g_bad_reset_grant
    $error("shift_arbiter: RESET_GRANT must be 0 or 1");
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef SHIFT_ARB_RR_EN
  logic last_q, last_d;

  // Contention goes to the index that did not win last; a lone valid wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else begin
      grant = req1_valid;
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= (RESET_GRANT == 0) ? 1'b1 : 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign grant = ~req0_valid;
`endif

  assign grant_valid = grant ? req1_valid : req0_valid;

  // Ready is gated with rst so reset forces it low without waiting for an edge.
  assign accept     = (state_q == IDLE) && !rst && grant_valid;
  assign req0_ready = (state_q == IDLE) && !rst && !grant && req0_valid;
  assign req1_ready = (state_q == IDLE) && !rst &&  grant && req1_valid;

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    shf_a_d    = shf_a_q;
    shf_b_d    = shf_b_q;
    shf_aluc_d = shf_aluc_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_cf_d   = rsp_cf_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = EXEC;
          shf_a_d    = grant ? req1_amt  : req0_amt;
          shf_b_d    = grant ? req1_data : req0_data;
          shf_aluc_d = grant ? req1_op   : req0_op;
          rsp_id_d   = grant;
        end
      end
      EXEC: begin
        state_d    = RESP;
        rsp_data_d = shf_result;
        // A zero-length shift moves no bit out, whatever the shifter reports.
        rsp_cf_d   = (shf_a_q == '0) ? 1'b0 : shf_cf;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shf_a_q    <= '0;
      shf_b_q    <= '0;
      shf_aluc_q <= '0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_cf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shf_a_q    <= shf_a_d;
      shf_b_q    <= shf_b_d;
      shf_aluc_q <= shf_aluc_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_cf_q   <= rsp_cf_d;
    end
  end

  assign shf_a     = shf_a_q;
  assign shf_b     = shf_b_q;
  assign shf_aluc  = shf_aluc_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_cf    = rsp_cf_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//
// Self-checking bench for shift_arbiter. Provides the external shifter, drives
// requests, and scoreboards every accepted request against its response.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_amt, req1_amt;
  logic [31:0] req0_data, req1_data;
  logic [1:0]  req0_op, req1_op;
  logic [4:0]  shf_a;
  logic [31:0] shf_b;
  logic [1:0]  shf_aluc;
  logic [31:0] shf_result;
  logic        shf_cf;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_cf;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_acc   = 0;
  int unsigned cyc     = 0;

  typedef struct {
    logic        id;
    logic [4:0]  amt;
    logic [31:0] data;
    logic [1:0]  op;
    logic [31:0] res;
    logic        cf;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  logic gq[$];
  exp_t exec_exp;
  exp_t mon_e;
  bit   exec_chk = 1'b0;
  bit   rsp_seen = 1'b0;
  logic a0, a1;
  logic [32:0] mon_r;

  always #5 clk = ~clk;

  shift_arbiter #(.RESET_GRANT(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_amt   (req0_amt),
    .req0_data  (req0_data),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_amt   (req1_amt),
    .req1_data  (req1_data),
    .req1_op    (req1_op),
    .shf_a      (shf_a),
    .shf_b      (shf_b),
    .shf_aluc   (shf_aluc),
    .shf_result (shf_result),
    .shf_cf     (shf_cf),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_cf     (rsp_cf)
  );

  // Reference shift: returns {carry, result}; carry is the last bit shifted out.
  function automatic logic [32:0] ref_shift(input logic [1:0] op, input logic [4:0] amt,
                                            input logic [31:0] d);
    logic [31:0] r;
    logic        c;
    int unsigned k;
    k = amt;
    case (op)
      2'b00:   r = $signed(d) >>> amt;
      2'b01:   r = d >> amt;
      default: r = d << amt;
    endcase
    if (k == 0)     c = 1'b0;
    else if (op[1]) c = d[32 - k];
    else            c = d[k - 1];
    return {c, r};
  endfunction

  // External shifter; its carry is forced high for zero-length shifts so the
  // DUT's masking of that case is observable.
  always_comb begin
    {shf_cf, shf_result} = ref_shift(shf_aluc, shf_a, shf_b);
    if (shf_a == '0) shf_cf = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exec_chk = 1'b0;
      rsp_seen = 1'b0;
    end else begin
      cyc++;
      if (exec_chk) begin
        chk("exec_shf_a",    {27'b0, shf_a},    {27'b0, exec_exp.amt});
        chk("exec_shf_b",    shf_b,             exec_exp.data);
        chk("exec_shf_aluc", {30'b0, shf_aluc}, {30'b0, exec_exp.op});
        exec_chk = 1'b0;
      end
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a0 || a1) begin
        chk("accept_count", 32'(a0) + 32'(a1), 1);
        mon_e.id   = a1;
        mon_e.amt  = a1 ? req1_amt  : req0_amt;
        mon_e.data = a1 ? req1_data : req0_data;
        mon_e.op   = a1 ? req1_op   : req0_op;
        mon_r      = ref_shift(mon_e.op, mon_e.amt, mon_e.data);
        mon_e.res  = mon_r[31:0];
        mon_e.cf   = mon_r[32];
        mon_e.cyc  = cyc;
        sb.push_back(mon_e);
        gq.push_back(a1);
        exec_exp = mon_e;
        exec_chk = 1'b1;
        n_acc++;
      end
      if (rsp_valid) begin
        chk("resp_ready0", {31'b0, req0_ready}, 0);
        chk("resp_ready1", {31'b0, req1_ready}, 0);
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          if (sb.size() != 0) chk("latency", cyc - sb[0].cyc, 2);
        end
        if (rsp_ready) begin
          chk("sb_has_entry", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("rsp_id",   {31'b0, rsp_id}, {31'b0, mon_e.id});
            chk("rsp_data", rsp_data,        mon_e.res);
            chk("rsp_cf",   {31'b0, rsp_cf}, {31'b0, mon_e.cf});
          end
          rsp_seen = 1'b0;
        end
      end
    end
  end

  task automatic reset_vals(input string tag);
    chk({tag, "_rdy0"},     {31'b0, req0_ready}, 0);
    chk({tag, "_rdy1"},     {31'b0, req1_ready}, 0);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 0);
    chk({tag, "_rsp_id"},   {31'b0, rsp_id},     0);
    chk({tag, "_rsp_data"}, rsp_data,            0);
    chk({tag, "_rsp_cf"},   {31'b0, rsp_cf},     0);
    chk({tag, "_shf_a"},    {27'b0, shf_a},      0);
    chk({tag, "_shf_b"},    shf_b,               0);
    chk({tag, "_shf_aluc"}, {30'b0, shf_aluc},   0);
  endtask

  // Present a request and hold it until accepted; returns 1ns after the accept edge.
  task automatic send(input logic id, input logic [4:0] amt, input logic [31:0] d,
                      input logic [1:0] op);
    bit          done;
    int unsigned w;
    done = 1'b0;
    w    = 0;
    if (id) begin
      req1_amt = amt; req1_data = d; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_amt = amt; req0_data = d; req0_op = op; req0_valid = 1'b1;
    end
    while (!done && w < 20) begin
      @(negedge clk);
      done = id ? (req1_ready === 1'b1) : (req0_ready === 1'b1);
      w++;
    end
    chk("accept_in_time", 32'(done), 1);
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned w;
    w = 0;
    while ((sb.size() != 0 || rsp_valid) && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  sa;
    logic [31:0] sbv;
    logic [1:0]  sop;
    int unsigned acc0, rv, w;

    rst = 1'b1;
    req0_valid = 1'b0; req0_amt = '0; req0_data = '0; req0_op = '0;
    req1_valid = 1'b0; req1_amt = '0; req1_data = '0; req1_op = '0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_vals("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors
    send(1'b0, 5'd4, 32'h8000_00F0, 2'b00);
    wait_drain();
    send(1'b1, 5'd1, 32'h8000_0001, 2'b10);
    wait_drain();
    send(1'b0, 5'd0, 32'h1234_5678, 2'b01);
    wait_drain();
    send(1'b1, 5'd31, 32'h8000_0000, 2'b00);
    send(1'b0, 5'd31, 32'h0000_0001, 2'b11);
    wait_drain();

    // Random back-to-back traffic
    for (int i = 0; i < 10; i++) begin
      send(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 2'($urandom));
    end
    wait_drain();

    // Response back-pressure; a short req1 pulse during RESP must be ignored
    acc0 = n_acc;
    rsp_ready = 1'b0;
    send(1'b0, 5'd8, 32'hF0F0_12B4, 2'b01);
    w = 0;
    while (!rsp_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    req1_amt = 5'd3; req1_data = 32'hAAAA_5555; req1_op = 2'b10;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_valid", {31'b0, rsp_valid}, 1);
      chk("hold_data",  rsp_data, 32'h00F0_F012);
      chk("hold_cf",    {31'b0, rsp_cf}, 1);
      chk("hold_ready", {30'b0, req0_ready, req1_ready}, 0);
      if (i == 1) req1_valid = 1'b1;
      if (i == 3) req1_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hs_valid", {31'b0, rsp_valid}, 1);
    @(posedge clk);
    #1;
    chk("back_idle_valid", {31'b0, rsp_valid}, 0);
    req0_amt = 5'd2; req0_data = 32'h0000_0003; req0_op = 2'b10; req0_valid = 1'b1;
    #1;
    chk("back_idle_ready", {31'b0, req0_ready}, 1);
    send(1'b0, 5'd2, 32'h0000_0003, 2'b10);
    wait_drain();
    chk("pulse_ignored", n_acc - acc0, 2);

    // shf_* must not follow request inputs while not executing
    sa = shf_a; sbv = shf_b; sop = shf_aluc;
    req0_amt = ~sa; req0_data = ~sbv; req0_op = ~sop;
    req1_amt = ~sa; req1_data = ~sbv; req1_op = ~sop;
    #1;
    chk("idle_shf_a",    {27'b0, shf_a},    {27'b0, sa});
    chk("idle_shf_b",    shf_b,             sbv);
    chk("idle_shf_aluc", {30'b0, shf_aluc}, {30'b0, sop});

    // Asynchronous reset during EXEC discards the operation
    send(1'b1, 5'd7, 32'hDEAD_BEEF, 2'b11);
    #1;
    rst = 1'b1;
    req0_valid = 1'b1;
    #1;
    reset_vals("rst_exec");
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    rst = 1'b0;
    rv = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) rv++;
    end
    chk("no_rsp_after_rst", rv, 0);

    // Continuous contention straight out of reset
    @(posedge clk);
    #1;
    gq.delete();
    req0_amt = 5'd3; req0_data = 32'h0000_00F0; req0_op = 2'b01;
    req1_amt = 5'd2; req1_data = 32'hFFFF_0000; req1_op = 2'b00;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    w = 0;
    while (gq.size() < 4 && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("grant_count", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
`ifdef SHIFT_ARB_RR_EN
      chk("grant_order", {31'b0, gq[i]}, 32'(i % 2));
`else
      chk("grant_order", {31'b0, gq[i]}, 0);
`endif
    end
    wait_drain();

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
